ham_encoder_tx: RTL and testbench



---
 rtl/ham_pkg.sv | 22 ++
 rtl/ham_encode.sv | 28 ++
 rtl/ham_encoder_tx.sv | 96 +++++++++
 tb/tb_ham_encoder_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// ============================================================================
// Module   : ham_pkg
// Brief    : Shared types and constants for the Hamming(7,4) transmit path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ham_pkg;

  localparam int CODE_BITS = 7;

  typedef bit [3:0]           nibble_t;
  typedef bit [CODE_BITS-1:0] codeword_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/ham_encode.sv
// ============================================================================
// Module   : ham_encode
// Brief    : Combinational Hamming(7,4) encoder, nibble in, codeword out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ham_encode
  import ham_pkg::*;
(
  input  nibble_t   i_data,
  output codeword_t o_code
);

  // Data sits at positions 3,5,6,7; parity at the power-of-two positions.
  assign o_code = {
    i_data[3],
    i_data[2],
    i_data[1],
    i_data[1] ^ i_data[2] ^ i_data[3],
    i_data[0],
    i_data[0] ^ i_data[2] ^ i_data[3],
    i_data[0] ^ i_data[1] ^ i_data[3]
  };

endmodule

`default_nettype wire

// File: rtl/ham_encoder_tx.sv
// ============================================================================
// Module   : ham_encoder_tx
// Brief    : Hamming(7,4) serial transmitter with per-frame error injection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ham_encoder_tx
  import ham_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [2:0] err_pos,
  output logic       sout,
  output logic       sout_valid,
  output logic       frame_start,
  output logic [6:0] codeword,
  output logic       busy
);

  localparam logic [7:0] c_last_cyc = 8'(BIT_CYCLES - 1);
  localparam logic [2:0] c_last_bit = 3'(CODE_BITS - 1);

  tx_state_t r_state;
  tx_state_t w_state_nxt;
  codeword_t r_codeword;
  logic [2:0] r_bit_idx;
  logic [7:0] r_cyc_cnt;

  codeword_t w_code;
  codeword_t w_inj;
  logic      w_last_slot;
  logic      w_ready;
  logic      w_xfer;

  ham_encode u_encode (
    .i_data (nibble_t'(data_in)),
    .o_code (w_code)
  );

  always_comb begin
    w_inj       = '0;
    w_last_slot = (r_state == SEND) && (r_bit_idx == c_last_bit) &&
                  (r_cyc_cnt == c_last_cyc);
    w_ready     = (r_state == IDLE) || w_last_slot;
    w_xfer      = data_valid && w_ready;
    w_state_nxt = r_state;
    if (err_pos != 3'd0) begin
      w_inj[err_pos - 3'd1] = 1'b1;
    end
    case (r_state)
      IDLE:    if (w_xfer) w_state_nxt = SEND;
      // A transfer in the final slot keeps us in SEND for a gapless next frame.
      SEND:    if (w_last_slot && !w_xfer) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_codeword <= '0;
      r_bit_idx  <= '0;
      r_cyc_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_codeword <= w_code ^ w_inj;
        r_bit_idx  <= '0;
        r_cyc_cnt  <= '0;
      end else if (r_state == SEND) begin
        if (r_cyc_cnt == c_last_cyc) begin
          r_cyc_cnt <= '0;
          r_bit_idx <= w_last_slot ? 3'd0 : r_bit_idx + 3'd1;
        end else begin
          r_cyc_cnt <= r_cyc_cnt + 8'd1;
        end
      end
    end
  end

  assign data_ready  = w_ready;
  assign busy        = (r_state == SEND);
  assign sout_valid  = (r_state == SEND);
  assign sout        = (r_state == SEND) ? r_codeword[r_bit_idx] : 1'b0;
  assign frame_start = (r_state == SEND) && (r_bit_idx == 3'd0) && (r_cyc_cnt == 8'd0);
  assign codeword    = r_codeword;

endmodule

`default_nettype wire

// File: tb/tb_ham_encoder_tx.sv
// ============================================================================
// Module   : tb_ham_encoder_tx
// Brief    : Scoreboard bench for ham_encoder_tx with a syndrome-decoding model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ham_encoder_tx;

  localparam int BC    = 3;
  localparam int FRAME = 7 * BC;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] cw;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic [2:0] err_pos = '0;
  logic       data_ready;
  logic       sout;
  logic       sout_valid;
  logic       frame_start;
  logic [6:0] codeword;
  logic       busy;

  ham_encoder_tx #(.BIT_CYCLES(BC)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .err_pos     (err_pos),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .codeword    (codeword),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Hamming positions 1..7: parity at 1,2,4 covers every position sharing that bit.
  function automatic logic [6:0] enc(input logic [3:0] n, input logic [2:0] e);
    logic [6:0] c;
    c = '0;
    c[2] = n[0]; c[4] = n[1]; c[5] = n[2]; c[6] = n[3];
    for (int p = 1; p <= 4; p = p * 2)
      for (int q = 1; q <= 7; q++)
        if ((q & p) != 0 && q != p) c[p-1] = c[p-1] ^ c[q-1];
    if (e != 3'd0) c[e-1] = ~c[e-1];
    return c;
  endfunction

  function automatic logic [3:0] decode(input logic [6:0] w);
    int s;
    s = 0;
    for (int q = 1; q <= 7; q++) if (w[q-1]) s = s ^ q;
    if (s != 0) w[s-1] = ~w[s-1];
    return {w[6], w[5], w[4], w[2]};
  endfunction

  bit         mon_active = 0;
  bit         exp_start = 0;
  int         mon_k = 0;
  exp_t       mon_exp;
  logic [6:0] rx = '0;
  logic [6:0] last_cw = '0;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 0;
      exp_start  = 0;
      exp_q.delete();
      last_cw    = '0;
    end else begin
      if (exp_start) begin
        chk("frame_start_due", frame_start, 1);
        exp_start = 0;
      end
      if (!mon_active && frame_start) begin
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          chk("codeword", codeword, mon_exp.cw);
          last_cw    = mon_exp.cw;
          mon_active = 1;
          mon_k      = 0;
        end
      end
      if (mon_active) begin
        chk("sout_valid", sout_valid, 1);
        chk("busy", busy, 1);
        chk("frame_start", frame_start, mon_k == 0);
        chk("data_ready_send", data_ready, mon_k == FRAME - 1);
        chk("sout", sout, mon_exp.cw[mon_k / BC]);
        rx[mon_k / BC] = sout;
        mon_k++;
        if (mon_k == FRAME) begin
          mon_active = 0;
          chk("decoded", decode(rx), mon_exp.nib);
        end
      end else begin
        chk("idle_ready", data_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_sout_valid", sout_valid, 0);
        chk("idle_sout", sout, 0);
        chk("idle_codeword_hold", codeword, last_cw);
      end
      if (data_valid && data_ready) begin
        exp_q.push_back('{nib: data_in, cw: enc(data_in, err_pos)});
        exp_start = 1;
      end
    end
  end

  task automatic send(input logic [3:0] n, input logic [2:0] e);
    int t;
    bit ok;
    t  = 0;
    ok = 0;
    data_in    = n;
    err_pos    = e;
    data_valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = data_ready && !reset;
      t++;
    end
    chk("send_accept", ok, 1);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || mon_active || exp_q.size() != 0) && t < 500);
    chk("idle_reached", busy || mon_active, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, data_ready, 1);
    chk({tag, "_sout"}, sout, 0);
    chk({tag, "_sout_valid"}, sout_valid, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_codeword"}, codeword, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;

    send(4'b0001, 3'd0); wait_idle(); chk("cw_0001", codeword, 7'b0000111);
    send(4'b0110, 3'd0); wait_idle(); chk("cw_0110", codeword, 7'b0110011);
    send(4'b1111, 3'd0); wait_idle(); chk("cw_1111", codeword, 7'b1111111);
    send(4'b0001, 3'd5); wait_idle(); chk("cw_0001_e5", codeword, 7'b0010111);

    // Back-to-back: valid stays high, so each nibble waits for the frame-end slot.
    for (int n = 0; n < 16; n++) send(4'(n), 3'd0);
    for (int e = 1; e <= 7; e++) send(4'b0001, 3'(e));
    wait_idle();

    repeat (40) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
      end
      send(4'($urandom), 3'($urandom));
    end
    wait_idle();

    send(4'b1010, 3'd3);
    repeat (3 * BC) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("midrst");
    reset = 1'b0;
    send(4'b1010, 3'd0);
    wait_idle();
    chk("cw_after_rst", codeword, 7'b1010010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
